// File: rtl/nf_reg_file_ext_if.sv
// Register file access bundle: read ports, write port, clear request and debug read port.
// The core side drives through master; the register file sits on slave.
interface nf_reg_file_ext_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2
);
  logic [RD_PORTS*ADDR_W-1:0] ra;
  logic [RD_PORTS*DATA_W-1:0] rd;
  logic [ADDR_W-1:0]          wa;
  logic [DATA_W-1:0]          wd;
  logic                       we;
  logic                       clr_req;
  logic                       busy;
  logic [ADDR_W-1:0]          ra0;
  logic [DATA_W-1:0]          rd0;

  modport master (
    output ra, wa, wd, we, clr_req, ra0,
    input  rd, busy, rd0
  );

  modport slave (
    input  ra, wa, wd, we, clr_req, ra0,
    output rd, busy, rd0
  );
endinterface

// File: rtl/nf_reg_file_ext.sv
// Parametrised multi-read-port register file with optional write-through bypass and a
// hardware clear sequencer that zeroes every entry after reset or on request.
module nf_reg_file_ext #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_R0  = 1
) (
  input  logic          clk,
  input  logic          rst,
  nf_reg_file_ext_if.slave bus
);

  typedef enum logic {StClear, StIdle} state_e;

  localparam logic [ADDR_W:0]   RegNum  = (ADDR_W+1)'(REG_NUM);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(REG_NUM - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy;
  logic              wr_legal;

  // Indexed over the full address space; entries at or above REG_NUM are never written or read.
  logic [DATA_W-1:0] regs [2**ADDR_W];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < RegNum) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  assign busy     = (state_q == StClear);
  assign wr_legal = bus.we && !busy && addr_ok(bus.wa);
  assign bus.busy = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_cnt_q == LastIdx) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (bus.clr_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  // Storage is initialised only by the clear sequence, never by rst.
  always_ff @(posedge clk) begin
    if (busy) begin
      regs[clr_cnt_q] <= '0;
    end else if (wr_legal) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.ra[i*ADDR_W +: ADDR_W];
    // wr_legal already excludes busy, so bypass never leaks data during a clear.
    assign bus.rd[i*DATA_W +: DATA_W] =
        (busy || !addr_ok(addr))                       ? '0     :
        ((BYPASS != 0) && wr_legal && bus.wa == addr)  ? bus.wd :
                                                         regs[addr];
  end

  assign bus.rd0 = (busy || !addr_ok(bus.ra0)) ? '0 : regs[bus.ra0];

endmodule

// File: tb/tb_nf_reg_file_ext.sv
// Bench for nf_reg_file_ext: three configurations share one stimulus stream and are checked
// every cycle against an array-based reference model.
module tb_nf_reg_file_ext;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] ra;
  logic [AW-1:0]    wa, ra0;
  logic [DW-1:0]    wd;
  logic             we, clr_req;

  nf_reg_file_ext_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP)) bus0 ();
  nf_reg_file_ext_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP)) bus1 ();
  nf_reg_file_ext_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP)) bus2 ();

  assign {bus0.ra, bus0.wa, bus0.wd, bus0.we, bus0.clr_req, bus0.ra0} = {ra, wa, wd, we, clr_req, ra0};
  assign {bus1.ra, bus1.wa, bus1.wd, bus1.we, bus1.clr_req, bus1.ra0} = {ra, wa, wd, we, clr_req, ra0};
  assign {bus2.ra, bus2.wa, bus2.wd, bus2.we, bus2.clr_req, bus2.ra0} = {ra, wa, wd, we, clr_req, ra0};

  nf_reg_file_ext #(.DATA_W(DW), .REG_NUM(32), .ADDR_W(AW), .RD_PORTS(NP), .BYPASS(1), .ZERO_R0(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  nf_reg_file_ext #(.DATA_W(DW), .REG_NUM(32), .ADDR_W(AW), .RD_PORTS(NP), .BYPASS(0), .ZERO_R0(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  nf_reg_file_ext #(.DATA_W(DW), .REG_NUM(16), .ADDR_W(AW), .RD_PORTS(NP), .BYPASS(1), .ZERO_R0(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference model: contents per config plus remaining clear cycles.
  int          regnum [3] = '{32, 32, 16};
  bit          byp    [3] = '{1, 0, 1};
  bit          z0     [3] = '{1, 0, 1};
  logic [31:0] mem    [3][32];
  int          left   [3];

  int n_asserts = 0;
  int n_fail    = 0;

  function automatic bit legal(int c, int a);
    return (a < regnum[c]) && !(z0[c] && a == 0);
  endfunction

  function automatic logic [31:0] exp_rd(int c, int a, bit dbg);
    if (left[c] > 0 || !legal(c, a)) return '0;
    if (!dbg && byp[c] && we && int'(wa) == a && legal(c, int'(wa))) return wd;
    return mem[c][a];
  endfunction

  task automatic start_clear(int c);
    for (int i = 0; i < 32; i++) mem[c][i] = '0;
    left[c] = regnum[c];
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int c, logic b, logic [NP*DW-1:0] rdv, logic [DW-1:0] r0);
    chk($sformatf("cfg%0d busy", c), {31'b0, b}, {31'b0, left[c] > 0});
    for (int p = 0; p < NP; p++)
      chk($sformatf("cfg%0d rd%0d addr=%0d", c, p, ra[p*AW +: AW]), rdv[p*DW +: DW],
          exp_rd(c, int'(ra[p*AW +: AW]), 1'b0));
    chk($sformatf("cfg%0d rd0dbg addr=%0d", c, ra0), r0, exp_rd(c, int'(ra0), 1'b1));
  endtask

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (rst) start_clear(c);
      else if (left[c] > 0) left[c]--;
      else begin
        if (we && legal(c, int'(wa))) mem[c][wa] = wd;
        if (clr_req) start_clear(c);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_dut(0, bus0.busy, bus0.rd, bus0.rd0);
    check_dut(1, bus1.busy, bus1.rd, bus1.rd0);
    check_dut(2, bus2.busy, bus2.rd, bus2.rd0);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(bit w, int a, logic [31:0] d, int r0p, int r1p, int rdbg, bit cr);
    we      = w;
    wa      = AW'(a);
    wd      = d;
    ra      = {AW'(r1p), AW'(r0p)};
    ra0     = AW'(rdbg);
    clr_req = cr;
  endtask

  task automatic drive_random(int clr_odds);
    drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), ($urandom_range(0, clr_odds) == 0));
  endtask

  initial begin
    for (int c = 0; c < 3; c++) start_clear(c);
    drive(0, 0, '0, 0, 0, 0, 0);

    // Power-on reset, then the full clear with random traffic that must be ignored.
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 34; i++) begin
      drive_random(3);
      cycle();
    end
    drive(0, 0, '0, 0, 0, 0, 0);
    repeat (2) cycle();

    // Write then read on port 1 and the debug port.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);  cycle();
    drive(0, 0, '0, 0, 5, 5, 0);             cycle();

    // Same-cycle bypass, then the stored value.
    drive(1, 7, 32'h0000_1234, 7, 0, 7, 0);  cycle();
    drive(0, 0, '0, 7, 7, 7, 0);             cycle();

    // Register 0 and out-of-range writes.
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);  cycle();
    drive(0, 0, '0, 0, 0, 0, 0);             cycle();
    drive(1, 20, 32'hAAAA_5555, 20, 20, 20, 0); cycle();
    drive(0, 0, '0, 20, 20, 20, 0);          cycle();

    // Fill, request a clear with a concurrent write, write during busy, read everything back.
    for (int i = 1; i < 32; i++) begin
      drive(1, i, 32'(i), i, i - 1, i, 0);
      cycle();
    end
    drive(1, 3, 32'h0BAD_F00D, 3, 4, 3, 1);  cycle();
    for (int i = 0; i < 33; i++) begin
      drive(1, i % 32, $urandom, i % 32, 31 - (i % 32), i % 32, 1'($urandom_range(0, 1)));
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, '0, i, i ^ 1, i, 0);
      cycle();
    end

    // Reset while the clear counter sits at 10.
    drive(0, 0, '0, 1, 2, 3, 1);             cycle();
    drive(0, 0, '0, 1, 2, 3, 0);
    repeat (10) cycle();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) start_clear(c);
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 34; i++) begin
      drive(1, i % 32, $urandom, i % 32, 5, 7, 0);
      cycle();
    end

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 300; i++) begin
      drive_random(40);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
